// File: rtl/onchip_mem_arbiter.sv
// Two Avalon-MM masters sharing one single-port on-chip RAM.
// Round-robin arbitration with a bounded hold count and a one-cycle tagged read return.
module onchip_mem_arbiter #(
   parameter int ADDR_W   = 11,
   parameter int DATA_W   = 32,
   parameter int MAX_HOLD = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,
   output logic [ADDR_W-1:0]   ram_address,
   output logic [DATA_W/8-1:0] ram_byteenable,
   output logic                ram_chipselect,
   output logic                ram_write,
   output logic [DATA_W-1:0]   ram_writedata,
   output logic                ram_clken,
   input  logic [DATA_W-1:0]   ram_readdata
);
   localparam int         BE_W       = DATA_W / 8;
   localparam logic [3:0] HOLD_MAX_C = 4'(MAX_HOLD);
   localparam logic [3:0] HOLD_SAT_C = 4'd15;

   logic       req0_s;
   logic       req1_s;
   logic       grant_s;
   logic       winner_s;
   logic       win_read_s;
   logic       win_write_s;
   logic       rd_acc_s;
   logic       last_r;
   logic [3:0] hold_cnt_r;
   logic       rd_pend_r;
   logic       rd_owner_r;

   assign req0_s = m0_read | m0_write;
   assign req1_s = m1_read | m1_write;

   // Arbitration. A zero hold count (fresh from reset) hands contention away from last_r, i.e. to m0.
   always_comb begin
      grant_s  = 1'b0;
      winner_s = 1'b0;
      if (!reset_n) begin
         grant_s  = 1'b0;
         winner_s = 1'b0;
      end else if (req0_s && req1_s) begin
         grant_s = 1'b1;
         if ((hold_cnt_r != 4'd0) && (hold_cnt_r < HOLD_MAX_C)) begin
            winner_s = last_r;
         end else begin
            winner_s = ~last_r;
         end
      end else if (req0_s) begin
         grant_s  = 1'b1;
         winner_s = 1'b0;
      end else if (req1_s) begin
         grant_s  = 1'b1;
         winner_s = 1'b1;
      end else begin
         grant_s  = 1'b0;
         winner_s = 1'b0;
      end
   end

   // Winner's command onto the RAM port; all zero when nobody is granted.
   always_comb begin
      ram_address    = {ADDR_W{1'b0}};
      ram_byteenable = {BE_W{1'b0}};
      ram_writedata  = {DATA_W{1'b0}};
      win_read_s     = 1'b0;
      win_write_s    = 1'b0;
      if (grant_s) begin
         case (winner_s)
            1'b0: begin
               ram_address    = m0_address;
               ram_byteenable = m0_byteenable;
               ram_writedata  = m0_writedata;
               win_read_s     = m0_read;
               win_write_s    = m0_write;
            end
            1'b1: begin
               ram_address    = m1_address;
               ram_byteenable = m1_byteenable;
               ram_writedata  = m1_writedata;
               win_read_s     = m1_read;
               win_write_s    = m1_write;
            end
            default: begin
               win_read_s  = 1'b0;
               win_write_s = 1'b0;
            end
         endcase
      end else begin
         win_read_s  = 1'b0;
         win_write_s = 1'b0;
      end
   end

   // A read that arrives together with a write is dropped; the write still executes.
   assign rd_acc_s         = grant_s & win_read_s & ~win_write_s;
   assign ram_chipselect   = grant_s;
   assign ram_write        = grant_s & win_write_s;
   assign ram_clken        = reset_n;
   assign m0_waitrequest   = ~(grant_s & ~winner_s);
   assign m1_waitrequest   = ~(grant_s & winner_s);
   assign m0_readdata      = ram_readdata;
   assign m1_readdata      = ram_readdata;
   assign m0_readdatavalid = rd_pend_r & ~rd_owner_r;
   assign m1_readdatavalid = rd_pend_r & rd_owner_r;

   // Ownership and saturating streak counter, advanced only on accepted transfers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_r     <= 1'b1;
         hold_cnt_r <= 4'd0;
      end else if (grant_s) begin
         if (winner_s == last_r) begin
            if (hold_cnt_r != HOLD_SAT_C) begin
               hold_cnt_r <= hold_cnt_r + 4'd1;
            end
         end else begin
            last_r     <= winner_s;
            hold_cnt_r <= 4'd1;
         end
      end
   end

   // Read return tag: valid exactly one cycle after the accept.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_pend_r  <= 1'b0;
         rd_owner_r <= 1'b0;
      end else begin
         rd_pend_r <= rd_acc_s;
         if (rd_acc_s) begin
            rd_owner_r <= winner_s;
         end
      end
   end
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Self-checking bench for onchip_mem_arbiter: directed scenarios then randomized traffic,
// checked cycle by cycle against a transaction-level reference model.
module tb_onchip_mem_arbiter;
   localparam int ADDR_W   = 11;
   localparam int DATA_W   = 32;
   localparam int BE_W     = 4;
   localparam int MAX_HOLD = 4;
   localparam int DEPTH    = 2048;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [ADDR_W-1:0] m0_address, m1_address;
   logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
   logic              m0_read, m0_write, m1_read, m1_write;
   logic [DATA_W-1:0] m0_writedata, m1_writedata;
   logic              m0_waitrequest, m1_waitrequest;
   logic [DATA_W-1:0] m0_readdata, m1_readdata;
   logic              m0_readdatavalid, m1_readdatavalid;
   logic [ADDR_W-1:0] ram_address;
   logic [BE_W-1:0]   ram_byteenable;
   logic              ram_chipselect, ram_write, ram_clken;
   logic [DATA_W-1:0] ram_writedata, ram_readdata;

   // RAM environment: registered address, unregistered data out
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] addr_q;
   assign ram_readdata = mem[addr_q];

   // Reference model state
   logic [DATA_W-1:0] ref_mem [DEPTH];
   int                ref_last   = -1;
   int                ref_streak = 0;
   bit                ref_pend   = 1'b0;
   int                ref_owner  = 0;
   logic [DATA_W-1:0] ref_data   = '0;
   int                last_w     = -1;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .ram_address(ram_address), .ram_byteenable(ram_byteenable),
      .ram_chipselect(ram_chipselect), .ram_write(ram_write),
      .ram_writedata(ram_writedata), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
   );

   function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(int m, bit rd, bit wr, logic [10:0] a, logic [3:0] be, logic [31:0] d);
      if (m == 0) begin
         m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
      end else begin
         m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
      end
   endtask

   task automatic idle_all();
      drive(0, 1'b0, 1'b0, 11'h000, 4'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 11'h000, 4'h0, 32'h0);
   endtask

   // One clock: check the cycle against the model, advance the model, then clock the RAM.
   task automatic cycle();
      bit r0, r1, rd, wr;
      int w;
      logic [10:0] a, c_a;
      logic [3:0]  be, c_be;
      logic [31:0] wd, c_wd;
      logic        c_cs, c_we, c_ck;
      #4;
      if (!reset_n) begin
         ref_pend = 1'b0; ref_last = -1; ref_streak = 0;
      end
      r0 = m0_read | m0_write;
      r1 = m1_read | m1_write;
      w  = -1;
      if (reset_n) begin
         if (r0 && r1) begin
            if (ref_last < 0)                  w = 0;
            else if (ref_streak >= MAX_HOLD)   w = 1 - ref_last;
            else                               w = ref_last;
         end else if (r0) w = 0;
         else if (r1)     w = 1;
      end
      a = 11'h0; be = 4'h0; wd = 32'h0; rd = 1'b0; wr = 1'b0;
      if (w == 0) begin
         a = m0_address; be = m0_byteenable; wd = m0_writedata; rd = m0_read; wr = m0_write;
      end else if (w == 1) begin
         a = m1_address; be = m1_byteenable; wd = m1_writedata; rd = m1_read; wr = m1_write;
      end
      chk("m0_waitrequest", 32'(m0_waitrequest), 32'(w != 0));
      chk("m1_waitrequest", 32'(m1_waitrequest), 32'(w != 1));
      chk("ram_chipselect", 32'(ram_chipselect), 32'(w >= 0));
      chk("ram_write", 32'(ram_write), 32'(wr));
      chk("ram_address", 32'(ram_address), 32'(a));
      chk("ram_byteenable", 32'(ram_byteenable), 32'(be));
      chk("ram_writedata", ram_writedata, wd);
      chk("ram_clken", 32'(ram_clken), 32'(reset_n));
      chk("m0_readdatavalid", 32'(m0_readdatavalid), 32'(ref_pend && ref_owner == 0));
      chk("m1_readdatavalid", 32'(m1_readdatavalid), 32'(ref_pend && ref_owner == 1));
      if (ref_pend) chk(ref_owner == 0 ? "m0_readdata" : "m1_readdata",
                        ref_owner == 0 ? m0_readdata : m1_readdata, ref_data);
      if (w >= 0) begin
         if (wr) ref_mem[a] = merge(ref_mem[a], wd, be);
         ref_pend = rd && !wr;
         if (ref_pend) begin
            ref_owner = w;
            ref_data  = ref_mem[a];
         end
         if (w == ref_last) ref_streak++;
         else begin
            ref_last   = w;
            ref_streak = 1;
         end
      end else begin
         ref_pend = 1'b0;
      end
      last_w = w;
      c_cs = ram_chipselect; c_we = ram_write; c_ck = ram_clken;
      c_a  = ram_address;    c_be = ram_byteenable; c_wd = ram_writedata;
      @(posedge clk);
      if (c_ck) begin
         if (c_cs && c_we) mem[c_a] = merge(mem[c_a], c_wd, c_be);
         addr_q = c_a;
      end
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      idle_all();
      cycle();
      cycle();
      reset_n = 1'b1;
   endtask

   initial begin
      int          acc0;
      int          m1_at;
      bit          busy [2];
      int          k;
      logic [31:0] v;
      for (int i = 0; i < DEPTH; i++) begin
         v = $urandom;
         mem[i]     = v;
         ref_mem[i] = v;
      end
      addr_q  = 11'h0;
      reset_n = 1'b0;
      idle_all();
      @(posedge clk);
      #1;

      // Idle after reset, then a single m0 read
      do_reset();
      drive(0, 1'b1, 1'b0, 11'h005, 4'hF, 32'h0);
      cycle();
      idle_all();
      chk("t1_m0_rdv", 32'(m0_readdatavalid), 32'd1);
      chk("t1_m1_rdv", 32'(m1_readdatavalid), 32'd0);
      cycle();

      // Contention on the first cycle after reset
      do_reset();
      drive(0, 1'b1, 1'b0, 11'h040, 4'hF, 32'h0);
      drive(1, 1'b1, 1'b0, 11'h041, 4'hF, 32'h0);
      cycle();
      drive(0, 1'b0, 1'b0, 11'h000, 4'h0, 32'h0);
      cycle();
      idle_all();
      cycle();
      cycle();

      // Fairness: streaming m0 against a held m1 write
      do_reset();
      acc0  = 0;
      m1_at = -1;
      drive(1, 1'b0, 1'b1, 11'h020, 4'hF, 32'hCAFEF00D);
      drive(0, 1'b1, 1'b0, 11'h100, 4'hF, 32'h0);
      for (int c = 1; c <= 20 && acc0 < 8; c++) begin
         #1;
         if (!m1_waitrequest && m1_at < 0) m1_at = c;
         cycle();
         if (last_w == 0) begin
            acc0++;
            if (acc0 < 8) drive(0, 1'b1, 1'b0, 11'(11'h100 + acc0), 4'hF, 32'h0);
            else          drive(0, 1'b0, 1'b0, 11'h000, 4'h0, 32'h0);
         end else if (last_w == 1) begin
            drive(1, 1'b0, 1'b0, 11'h000, 4'h0, 32'h0);
         end
      end
      chk("fair_m0_accepts", 32'(acc0), 32'd8);
      chk("fair_m1_slot", 32'(m1_at), 32'd5);
      idle_all();
      cycle();

      // Byte-enable merge at the top address
      drive(1, 1'b0, 1'b1, 11'h7FF, 4'hF, 32'h11223344);
      cycle();
      drive(1, 1'b0, 1'b1, 11'h7FF, 4'h3, 32'hAABBCCDD);
      cycle();
      drive(1, 1'b0, 1'b0, 11'h000, 4'h0, 32'h0);
      drive(0, 1'b1, 1'b0, 11'h7FF, 4'hF, 32'h0);
      cycle();
      idle_all();
      #1;
      chk("be_merge_data", m0_readdata, 32'h1122CCDD);
      cycle();

      // Reset asserted the cycle after an accepted read
      drive(0, 1'b1, 1'b0, 11'h005, 4'hF, 32'h0);
      cycle();
      reset_n = 1'b0;
      idle_all();
      #1;
      chk("rst_m0_rdv", 32'(m0_readdatavalid), 32'd0);
      chk("rst_clken", 32'(ram_clken), 32'd0);
      cycle();
      cycle();
      reset_n = 1'b1;
      drive(0, 1'b1, 1'b0, 11'h006, 4'hF, 32'h0);
      drive(1, 1'b1, 1'b0, 11'h007, 4'hF, 32'h0);
      #1;
      chk("rst_m0_priority", 32'(m0_waitrequest), 32'd0);
      cycle();
      idle_all();
      cycle();
      cycle();

      // Illegal read+write: write wins, no read return
      drive(1, 1'b1, 1'b1, 11'h010, 4'hF, 32'h00000005);
      cycle();
      idle_all();
      #1;
      chk("rw_no_rdv", 32'(m1_readdatavalid), 32'd0);
      cycle();
      drive(0, 1'b1, 1'b0, 11'h010, 4'hF, 32'h0);
      cycle();
      idle_all();
      #1;
      chk("rw_data", m0_readdata, 32'h00000005);
      cycle();

      // Randomized traffic; a request is held until accepted
      busy[0] = 1'b0;
      busy[1] = 1'b0;
      for (int n = 0; n < 300; n++) begin
         for (int m = 0; m < 2; m++) begin
            if (!busy[m]) begin
               k = int'($urandom_range(0, 3));
               if (k == 0) drive(m, 1'b0, 1'b0, 11'h000, 4'h0, 32'h0);
               else drive(m, k[0], ~k[0],
                          ($urandom_range(0, 9) == 0) ? 11'h7FF : 11'($urandom_range(0, 7)),
                          4'($urandom_range(1, 15)), $urandom);
               busy[m] = (k != 0);
            end
         end
         cycle();
         if (last_w >= 0) busy[last_w] = 1'b0;
      end
      idle_all();
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
